jtbubl_sdram_arb: RTL
=====================

Name: jtbubl_sdram_arb

Overview:
- Shares the single SDRAM read port between the ROM requesters: main, sub, MCU, sound and GFX.
- Each requester presents its chip-select and a 22-bit word address, with the region offset already added.
- The block round-robins grants, runs the req/ack/data_rdy handshake and returns the 32-bit word with a per-slot ok flag.
- It sits between the game-level ROM slot logic and the SDRAM controller, and also drives refresh_en.

Parameters:
- NSLOT, 5, number of requesters; slot 0 = main … slot 4 = GFX.
- AW, 22, SDRAM word address width.
- GFX_SLOT, 4, slot index that gets top priority while vblank is high.

Ports:
- clk  in  1  SDRAM clock.
- rstn  in  1  asynchronous reset, active low.
- downloading  in  1  ROM load in progress; arbitration suspended.
- vblank  in  1  high during vertical blank.
- slot_cs  in  NSLOT  per-slot request.
- slot_addr  in  NSLOT*AW  packed word addresses; slot i is bits [i*AW+:AW].
- slot_ok  out  NSLOT  data for the current slot_addr is valid.
- slot_dout  out  NSLOT*32  packed per-slot data words.
- sdram_req  out  1  read request to the SDRAM controller.
- sdram_addr  out  AW  address of the request.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  data_read is valid this cycle.
- data_read  in  32  SDRAM read data.
- refresh_en  out  1  controller may refresh.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; sdram_req = 0; sdram_addr = 0.
  - slot_ok = 0; slot_dout = 0; all valid bits and latched addresses = 0.
  - RR pointer = 0; refresh_en = 1.
- Per slot i:
  - Registers: lat_addr[i] (AW bits), valid[i], buf[i] (32 bits).
  - slot_ok[i] = slot_cs[i] & valid[i] & (slot_addr[i] == lat_addr[i]). This is combinational, so ok drops in the same cycle the address changes or cs falls.
  - slot_dout[i] = buf[i], held between fetches.
- pending[i] = slot_cs[i] & ~slot_ok[i] & ~downloading.
- State machine:
  - IDLE:
    - If any pending bit is set, select a winner. If vblank & pending[GFX_SLOT], the winner is GFX_SLOT. Otherwise the winner is the first pending slot at or after the RR pointer, wrapping from NSLOT-1 to 0.
    - On selection, register the winner index, set sdram_addr = slot_addr[winner] and sdram_req = 1, then go to WAIT_ACK. This gives 1 cycle from pending to req.
    - Set the RR pointer to winner+1, wrapping to 0 at NSLOT.
  - WAIT_ACK:
    - Hold sdram_req and sdram_addr until sdram_ack.
    - On sdram_ack: sdram_req = 0 on the next edge, go to WAIT_DATA.
    - If sdram_ack and data_rdy arrive in the same cycle, take the WAIT_DATA capture path immediately.
  - WAIT_DATA:
    - On data_rdy: buf[w] = data_read, lat_addr[w] = the address issued, valid[w] = 1, return to IDLE.
    - slot_ok[w] rises the cycle after data_rdy, provided the requester's address has not changed.
- Requester changes address mid-fetch: the fetch completes and the data is stored under the old address. ok stays low for the new address, and that slot re-arbitrates from IDLE.
- Requester drops cs mid-fetch: same rule; the fetch completes and data is stored.
- downloading high:
  - Clears every valid[i].
  - Blocks new grants.
  - An in-flight transaction still completes, so the controller handshake is never abandoned.
- refresh_en = (state == IDLE) & ~|pending.
- No combinational path from sdram_ack or data_rdy to sdram_req.

Optional Feature:
- Macro: JTBUBL_ARB_PREFETCH_EN.
- Defined:
  - After slot 0 (main) completes a fetch at address A, and if no slot is pending in IDLE, the block issues a speculative read of A+1 (wrapping at 2^AW).
  - The result goes into a second buffer for slot 0.
  - If slot 0 then asks for A+1, it is served from the second buffer with slot_ok asserted 1 cycle after the address change, and no new SDRAM access.
  - A real pending request always beats the prefetch in IDLE; a prefetch already granted is not aborted.
- Undefined: no prefetch logic, no second buffer; behaviour is exactly as above.

Decomposition:
- Package jtbubl_arb_pkg:
  - State enum {IDLE, WAIT_ACK, WAIT_DATA}.
  - Default NSLOT/AW constants.
  - Slot index constants MAIN/SUB/MCU/SND/GFX.
- Sub-module jtbubl_arb_rr: the combinational round-robin picker (pending, pointer, vblank override → winner index plus a found flag).

Test Plan:
- Basic fetch: slot 0 cs, address 0x00123; ack 2 cycles after req, data_rdy 3 cycles later with 0xDEADBEEF → slot_ok[0] high the cycle after data_rdy, slot_dout[0] = 0xDEADBEEF, exactly one req pulse.
- Fairness: slots 0, 1 and 3 all pending continuously with new addresses each fetch → grant order 0, 1, 3, 0, 1, 3; no slot starves.
- vblank override: RR pointer = 0 with slots 0 and 4 pending and vblank = 1 → slot 4 granted first; with vblank = 0 → slot 0 granted first.
- Address change mid-fetch: slot 2 changes from 0x100 to 0x104 during WAIT_DATA → ok[2] stays low, a second req is issued with sdram_addr = 0x104, then ok[2] rises.
- Reset mid-operation: rstn pulled low in WAIT_ACK → sdram_req drops immediately (asynchronously), all slot_ok = 0, state = IDLE.
- Download: downloading = 1 with slots pending → no req issued and refresh_en = 1; after downloading = 0, all previously valid slots refetch.

Source files
------------

// File: rtl/jtbubl_arb_pkg.sv
// jtbubl_arb_pkg: shared types and constants for the SDRAM ROM arbiter.
// Slot order is main, sub, MCU, sound, GFX.
package jtbubl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DATA
  } state_t;

  localparam int DEF_NSLOT = 5;
  localparam int DEF_AW    = 22;

  localparam int MAIN = 0;
  localparam int SUB  = 1;
  localparam int MCU  = 2;
  localparam int SND  = 3;
  localparam int GFX  = 4;

endpackage

// File: rtl/jtbubl_sdram_arb_if.sv
// jtbubl_sdram_arb_if: read-port handshake between the ROM arbiter
// and the SDRAM controller.
interface jtbubl_sdram_arb_if #(
  parameter int AW = jtbubl_arb_pkg::DEF_AW
);

  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   data_read;

  modport master (
    output sdram_req,
    output sdram_addr,
    input  sdram_ack,
    input  data_rdy,
    input  data_read
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    output sdram_ack,
    output data_rdy,
    output data_read
  );

endinterface

// File: rtl/jtbubl_arb_rr.sv
// jtbubl_arb_rr: combinational round-robin picker with a vblank
// override that favours the GFX slot.
module jtbubl_arb_rr #(
  parameter int NSLOT    = 5,
  parameter int GFX_SLOT = 4,
  parameter int IW       = $clog2(NSLOT)
) (
  input  logic [NSLOT-1:0] pending,
  input  logic [IW-1:0]    ptr,
  input  logic             vblank,
  output logic [IW-1:0]    win,
  output logic             found
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NSLOT; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NSLOT))
        sum = sum - (IW+1)'(NSLOT);
      idx = sum[IW-1:0];
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (vblank && pending[GFX_SLOT]) begin
      found = 1'b1;
      win   = IW'(GFX_SLOT);
    end
  end

endmodule

// File: rtl/jtbubl_sdram_arb.sv
// jtbubl_sdram_arb: shares the SDRAM read port between the ROM slots.
// Define JTBUBL_ARB_PREFETCH_EN for the slot-0 next-word prefetch.
module jtbubl_sdram_arb
  import jtbubl_arb_pkg::*;
#(
  parameter int NSLOT    = DEF_NSLOT,
  parameter int AW       = DEF_AW,
  parameter int GFX_SLOT = GFX
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                downloading,
  input  logic                vblank,
  input  logic [NSLOT-1:0]    slot_cs,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT-1:0]    slot_ok,
  output logic [NSLOT*32-1:0] slot_dout,
  jtbubl_sdram_arb_if.master  sdram,
  output logic                refresh_en
);

  localparam int IW = $clog2(NSLOT);

  state_t            state, state_nx;
  logic [AW-1:0]     lat_addr [NSLOT];
  logic [31:0]       dbuf     [NSLOT];
  logic [NSLOT-1:0]  valid;
  logic [NSLOT-1:0]  pending;
  logic [NSLOT-1:0]  hit_mask;
  logic [IW-1:0]     ptr, win, pick;
  logic              found;
  logic              grant, capture;

  always_comb begin
    slot_ok   = '0;
    slot_dout = '0;
    for (int i = 0; i < NSLOT; i++) begin
      slot_ok[i] = slot_cs[i] & valid[i]
                 & (slot_addr[i*AW+:AW] == lat_addr[i]);
      slot_dout[i*32+:32] = dbuf[i];
    end
  end

`ifdef JTBUBL_ARB_PREFETCH_EN
  logic          pf_arm, pf_busy, pf_valid;
  logic          pf_go, pf_hit;
  logic [AW-1:0] pf_addr;
  logic [31:0]   pf_buf;

  // a hit is served from the second buffer without an SDRAM access
  assign pf_hit = pf_valid & slot_cs[MAIN] & ~slot_ok[MAIN]
                & ~downloading
                & (slot_addr[MAIN*AW+:AW] == pf_addr);
  assign hit_mask = NSLOT'(pf_hit);
`else
  assign hit_mask = '0;
`endif

  assign pending = slot_cs & ~slot_ok & ~hit_mask
                 & {NSLOT{~downloading}};

  assign refresh_en = (state == IDLE) & ~|pending;

  jtbubl_arb_rr #(
    .NSLOT    (NSLOT),
    .GFX_SLOT (GFX_SLOT),
    .IW       (IW)
  ) u_rr (
    .pending (pending),
    .ptr     (ptr),
    .vblank  (vblank),
    .win     (pick),
    .found   (found)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    capture  = 1'b0;
`ifdef JTBUBL_ARB_PREFETCH_EN
    pf_go    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          grant    = 1'b1;
          state_nx = WAIT_ACK;
        end
`ifdef JTBUBL_ARB_PREFETCH_EN
        else if (pf_arm && !downloading) begin
          pf_go    = 1'b1;
          state_nx = WAIT_ACK;
        end
`endif
      end
      WAIT_ACK: begin
        if (sdram.sdram_ack) begin
          capture  = sdram.data_rdy;
          state_nx = sdram.data_rdy ? IDLE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (sdram.data_rdy) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdram.sdram_req  <= 1'b0;
      sdram.sdram_addr <= '0;
      win              <= '0;
      ptr              <= '0;
      valid            <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        lat_addr[i] <= '0;
        dbuf[i]     <= '0;
      end
`ifdef JTBUBL_ARB_PREFETCH_EN
      pf_arm   <= 1'b0;
      pf_busy  <= 1'b0;
      pf_valid <= 1'b0;
      pf_addr  <= '0;
      pf_buf   <= '0;
`endif
    end else begin
`ifdef JTBUBL_ARB_PREFETCH_EN
      if (pf_hit) begin
        dbuf[MAIN]     <= pf_buf;
        lat_addr[MAIN] <= pf_addr;
        valid[MAIN]    <= 1'b1;
        pf_valid       <= 1'b0;
        pf_arm         <= 1'b1;
      end
      if (pf_go) begin
        pf_busy          <= 1'b1;
        pf_arm           <= 1'b0;
        sdram.sdram_req  <= 1'b1;
        sdram.sdram_addr <= lat_addr[MAIN] + 1'b1;
      end
`endif
      if (grant) begin
        win              <= pick;
        ptr              <= (pick == IW'(NSLOT-1)) ? '0 : pick + 1'b1;
        sdram.sdram_req  <= 1'b1;
        sdram.sdram_addr <= slot_addr[pick*AW+:AW];
      end
      if (state == WAIT_ACK && sdram.sdram_ack)
        sdram.sdram_req <= 1'b0;
      if (capture) begin
`ifdef JTBUBL_ARB_PREFETCH_EN
        if (pf_busy) begin
          pf_buf   <= sdram.data_read;
          pf_addr  <= sdram.sdram_addr;
          pf_valid <= 1'b1;
          pf_busy  <= 1'b0;
        end else
`endif
        begin
          dbuf[win]     <= sdram.data_read;
          lat_addr[win] <= sdram.sdram_addr;
          valid[win]    <= 1'b1;
`ifdef JTBUBL_ARB_PREFETCH_EN
          if (win == IW'(MAIN)) pf_arm <= 1'b1;
`endif
        end
      end
      // a ROM load invalidates everything, even a word landing now
      if (downloading) begin
        valid <= '0;
`ifdef JTBUBL_ARB_PREFETCH_EN
        pf_valid <= 1'b0;
        pf_arm   <= 1'b0;
`endif
      end
    end
  end

endmodule
